// File: rtl/sd_spi_shifter_if.sv
// rtl/sd_spi_shifter_if.sv - strobe, data and handshake bundle for the SD SPI byte shifter
//
// Purpose: groups the sclk edge strobes, serial lines and the byte-level
// request/completion handshake of sd_spi_shifter into one connection.
// Signals:
//   sclk_rise, sclk_fall  one-clk sclk edge strobes from the edge detector
//   miso                  card data out, already synchronized to clk
//   start, poll, tx_byte  transfer request, poll-mode select, byte to send
//   mosi                  card data in, MSB first
//   busy, done            transfer in progress / one-clk completion pulse
//   rx_byte, timeout      last received byte / poll exhausted flag
// Modports: master drives requests and strobes, slave is the shifter.
interface sd_spi_shifter_if;
   logic       sclk_rise;
   logic       sclk_fall;
   logic       miso;
   logic       start;
   logic       poll;
   logic [7:0] tx_byte;
   logic       mosi;
   logic       busy;
   logic       done;
   logic [7:0] rx_byte;
   logic       timeout;

   modport master (
      output sclk_rise, sclk_fall, miso, start, poll, tx_byte,
      input  mosi, busy, done, rx_byte, timeout
   );

   modport slave (
      input  sclk_rise, sclk_fall, miso, start, poll, tx_byte,
      output mosi, busy, done, rx_byte, timeout
   );
endinterface

// File: rtl/sd_spi_shifter.sv
// rtl/sd_spi_shifter.sv - SPI mode 0 byte transceiver with 0xFF poll mode for SD cards
//
// Purpose: shifts one byte out on mosi and in from miso per request, driven by
// sclk edge strobes in the clk domain. In poll mode it keeps clocking 0xFF
// until the card returns a non-0xFF byte or MAX_POLL bytes have been clocked.
// Ports:
//   clk   system clock, all logic on its rising edge
//   rst   synchronous active-high reset
//   bus   sd_spi_shifter_if.slave (strobes, miso/mosi, start/poll/tx_byte,
//         busy/done/rx_byte/timeout)
module sd_spi_shifter #(
   parameter int MAX_POLL = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   sd_spi_shifter_if.slave      bus
);

   localparam int PW = $clog2(MAX_POLL) + 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLL - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    tx_sr_q, tx_sr_d;
   logic [7:0]    rx_sr_q, rx_sr_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [PW-1:0] poll_cnt_q, poll_cnt_d;
   logic          poll_mode_q, poll_mode_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          timeout_q, timeout_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tx_sr_q     <= 8'h00;
         rx_sr_q     <= 8'h00;
         bit_cnt_q   <= 4'd0;
         poll_cnt_q  <= '0;
         poll_mode_q <= 1'b0;
         rx_byte_q   <= 8'h00;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         poll_cnt_q  <= poll_cnt_d;
         poll_mode_q <= poll_mode_d;
         rx_byte_q   <= rx_byte_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      bit_cnt_d   = bit_cnt_q;
      poll_cnt_d  = poll_cnt_q;
      poll_mode_d = poll_mode_q;
      rx_byte_d   = rx_byte_q;
      timeout_d   = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               tx_sr_d     = bus.poll ? 8'hFF : bus.tx_byte;
               poll_mode_d = bus.poll;
               bit_cnt_d   = 4'd0;
               poll_cnt_d  = '0;
               state_d     = S_SHIFT;
            end
         end

         S_SHIFT: begin
            // Rise wins over a coincident fall: the sample is taken and the
            // fall is dropped, so mosi only moves on a clean fall.
            if (bus.sclk_rise) begin
               rx_sr_d   = {rx_sr_q[6:0], bus.miso};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  state_d = S_CHECK;
               end
            end else if (bus.sclk_fall) begin
               // A fall before the first rise keeps the MSB on the line.
               if (bit_cnt_q != 4'd0 && bit_cnt_q <= 4'd7) begin
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
               end
            end
         end

         S_CHECK: begin
            if (poll_mode_q && rx_sr_q == 8'hFF && poll_cnt_q < POLL_LAST) begin
               poll_cnt_d = poll_cnt_q + 1'b1;
               tx_sr_d    = 8'hFF;
               bit_cnt_d  = 4'd0;
               state_d    = S_SHIFT;
            end else begin
               rx_byte_d = rx_sr_q;
               timeout_d = poll_mode_q && (rx_sr_q == 8'hFF);
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Idle line is high; once busy the line follows the shift register MSB.
   assign bus.mosi    = (state_q == S_IDLE) ? 1'b1 : tx_sr_q[7];
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.rx_byte = rx_byte_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_sd_spi_shifter.sv
// tb/tb_sd_spi_shifter.sv - directed table-driven bench for sd_spi_shifter
module tb_sd_spi_shifter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   rises;

   sd_spi_shifter_if bus ();

   sd_spi_shifter #(.MAX_POLL(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] tx;
      logic [7:0] miso_b;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t vecs [5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] tx, input logic pl);
      bus.start   = 1'b1;
      bus.poll    = pl;
      bus.tx_byte = tx;
      tick();
      bus.start   = 1'b0;
      bus.poll    = 1'b0;
      bus.tx_byte = 8'h00;
      check("busy_after_start", {7'd0, bus.busy}, 8'd1);
   endtask

   // Eight rises with falls after rises 1..7; returns just after the edge
   // that sampled the 8th rise. simul: bit index that gets a coincident fall,
   // glitch: bit index after which start with tx_byte=0 is pulsed.
   task automatic clock_bits(input logic [7:0] mb, input logic [7:0] me,
                             input bit chk_mosi, input int simul, input int glitch);
      for (int i = 0; i < 8; i++) begin
         bus.miso = mb[7-i];
         if (chk_mosi) check($sformatf("mosi_bit%0d", 7-i), {7'd0, bus.mosi}, {7'd0, me[7-i]});
         bus.sclk_rise = 1'b1;
         bus.sclk_fall = (i == simul);
         tick();
         bus.sclk_rise = 1'b0;
         bus.sclk_fall = 1'b0;
         rises++;
         if (i == simul) check("mosi_after_simul", {7'd0, bus.mosi}, {7'd0, me[7-i]});
         if (i == 7) return;
         tick();
         if (i == glitch) begin
            bus.start   = 1'b1;
            bus.tx_byte = 8'h00;
         end
         tick();
         bus.start     = 1'b0;
         bus.sclk_fall = 1'b1;
         tick();
         bus.sclk_fall = 1'b0;
         tick();
      end
   endtask

   task automatic finish_check(input logic [7:0] exp_rx, input logic exp_to);
      check("done_in_check", {7'd0, bus.done}, 8'd0);
      check("busy_in_check", {7'd0, bus.busy}, 8'd1);
      tick();
      check("done_pulse", {7'd0, bus.done}, 8'd1);
      check("busy_in_done", {7'd0, bus.busy}, 8'd1);
      check("rx_byte", bus.rx_byte, exp_rx);
      check("timeout", {7'd0, bus.timeout}, {7'd0, exp_to});
      tick();
      check("done_cleared", {7'd0, bus.done}, 8'd0);
      check("busy_cleared", {7'd0, bus.busy}, 8'd0);
      check("mosi_idle", {7'd0, bus.mosi}, 8'd1);
   endtask

   task automatic between_poll_bytes();
      tick();
      check("poll_no_done_check", {7'd0, bus.done}, 8'd0);
      check("poll_mosi_check", {7'd0, bus.mosi}, 8'd1);
      tick();
      check("poll_no_done_shift", {7'd0, bus.done}, 8'd0);
      check("poll_busy_shift", {7'd0, bus.busy}, 8'd1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rises  = 0;
      rst           = 1'b1;
      bus.sclk_rise = 1'b0;
      bus.sclk_fall = 1'b0;
      bus.miso      = 1'b0;
      bus.start     = 1'b0;
      bus.poll      = 1'b0;
      bus.tx_byte   = 8'h00;

      vecs[0] = '{8'hA5, 8'h3C, 8'h3C};
      vecs[1] = '{8'h00, 8'hFF, 8'hFF};
      vecs[2] = '{8'hFF, 8'h00, 8'h00};
      vecs[3] = '{8'h5A, 8'hC3, 8'hC3};
      vecs[4] = '{8'h80, 8'h01, 8'h01};

      tick(); tick(); tick();
      rst = 1'b0;
      check("rst_mosi", {7'd0, bus.mosi}, 8'd1);
      check("rst_busy", {7'd0, bus.busy}, 8'd0);
      check("rst_done", {7'd0, bus.done}, 8'd0);
      check("rst_rx_byte", bus.rx_byte, 8'h00);
      check("rst_timeout", {7'd0, bus.timeout}, 8'd0);
      tick();

      // Table of normal (non-poll) transfers.
      for (int v = 0; v < 5; v++) begin
         do_start(vecs[v].tx, 1'b0);
         clock_bits(vecs[v].miso_b, vecs[v].tx, 1'b1, -1, -1);
         finish_check(vecs[v].exp_rx, 1'b0);
         tick();
      end

      // Poll success: 0xFF, 0xFF, 0x00 -> 24 rises.
      rises = 0;
      do_start(8'h00, 1'b1);
      clock_bits(8'hFF, 8'hFF, 1'b1, -1, -1);
      between_poll_bytes();
      clock_bits(8'hFF, 8'hFF, 1'b1, -1, -1);
      between_poll_bytes();
      clock_bits(8'h00, 8'hFF, 1'b1, -1, -1);
      check("poll_rises", 8'(rises), 8'd24);
      finish_check(8'h00, 1'b0);
      tick();

      // Poll timeout: miso held high for 8 bytes -> 64 rises, timeout.
      rises = 0;
      do_start(8'h12, 1'b1);
      for (int b = 0; b < 8; b++) begin
         clock_bits(8'hFF, 8'hFF, 1'b1, -1, -1);
         if (b < 7) between_poll_bytes();
      end
      check("timeout_rises", 8'(rises), 8'd64);
      finish_check(8'hFF, 1'b1);
      bus.miso = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.sclk_rise = 1'b1; tick(); bus.sclk_rise = 1'b0; tick();
         bus.sclk_fall = 1'b1; tick(); bus.sclk_fall = 1'b0; tick();
      end
      check("idle_strobes_busy", {7'd0, bus.busy}, 8'd0);
      check("idle_strobes_rx", bus.rx_byte, 8'hFF);
      tick();

      // Protocol edges: early fall, coincident rise+fall, start while busy.
      do_start(8'h96, 1'b0);
      bus.sclk_fall = 1'b1; tick(); bus.sclk_fall = 1'b0; tick();
      check("early_fall_mosi", {7'd0, bus.mosi}, 8'd1);
      clock_bits(8'h6B, 8'h96, 1'b1, 2, 4);
      finish_check(8'h6B, 1'b0);
      tick();

      // Reset mid-byte after 3 rises.
      do_start(8'hA5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.miso = 1'b1;
         bus.sclk_rise = 1'b1; tick(); bus.sclk_rise = 1'b0; tick(); tick();
         bus.sclk_fall = 1'b1; tick(); bus.sclk_fall = 1'b0; tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", {7'd0, bus.busy}, 8'd0);
      check("midrst_mosi", {7'd0, bus.mosi}, 8'd1);
      check("midrst_rx", bus.rx_byte, 8'h00);
      check("midrst_done", {7'd0, bus.done}, 8'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("midrst_no_done", {7'd0, bus.done}, 8'd0);
      end
      do_start(8'h5A, 1'b0);
      clock_bits(8'hC3, 8'h5A, 1'b1, -1, -1);
      finish_check(8'hC3, 1'b0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_spi_shifter.md
# sd_spi_shifter

SPI-mode byte transceiver for the SD card interface. It sits directly downstream of the sclk edge detector. It consumes single-cycle sclk rising and falling strobes in the system clock domain, drives MOSI, samples MISO, and assembles one byte per request. An optional poll mode clocks out 0xFF repeatedly until the card returns a non-0xFF byte (R1 response / start-token wait), bounded by a byte limit.

## Interface

Parameters:
- MAX_POLL, default 8: maximum bytes clocked in poll mode before declaring timeout (≥1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- sclk_rise  input  1  one-clk strobe: sclk rising edge detected.
- sclk_fall  input  1  one-clk strobe: sclk falling edge detected.
- miso  input  1  card data out, already synchronized to clk.
- start  input  1  transfer request; accepted only in IDLE.
- poll  input  1  sampled with start; 1 selects poll mode.
- tx_byte  input  8  byte to send; sampled with start; ignored in poll mode.
- mosi  output  1  card data in, MSB first.
- busy  output  1  high from the clk after start is accepted until return to IDLE.
- done  output  1  one-clk completion pulse.
- rx_byte  output  8  last completed received byte; held until the next completion.
- timeout  output  1  valid with done; 1 when poll mode exhausted MAX_POLL bytes, all 0xFF.

## Operation

- SPI mode 0: MISO is sampled on sclk rise. MOSI changes on sclk fall. The MSB is driven before the first rise.
- States: IDLE, SHIFT, CHECK, DONE.
- IDLE:
  - mosi=1, busy=0.
  - start=1 latches tx_sr = (poll ? 0xFF : tx_byte), poll_mode=poll, bit_cnt=0, poll_cnt=0, and moves to SHIFT.
  - mosi=tx_sr[7] from the next cycle.
- SHIFT, on sclk_rise:
  - rx_sr <= {rx_sr[6:0], miso}, bit_cnt++.
  - At bit_cnt 8 → CHECK.
- SHIFT, on sclk_fall:
  - If 1 ≤ bit_cnt ≤ 7, tx_sr <= tx_sr << 1 and mosi shows the next bit.
  - sclk_fall with bit_cnt=0 is ignored, so MOSI holds the MSB.
- CHECK (exactly one cycle):
  - If poll_mode, rx_sr==0xFF and poll_cnt < MAX_POLL-1: poll_cnt++, tx_sr=0xFF, bit_cnt=0 → SHIFT.
  - Otherwise → DONE, with rx_byte <= rx_sr and timeout <= poll_mode && rx_sr==0xFF.
  - Strobes arriving in CHECK are ignored; upstream guarantees ≥2 clk between strobes.
- DONE (one cycle): done=1, busy=1 → IDLE.
- sclk_rise and sclk_fall both high in the same cycle is illegal upstream. If it happens, the rise is processed and the fall is ignored.
- start while busy=1 is ignored, with no effect on the transfer in progress.
- Counters: bit_cnt is 4 bits. poll_cnt is $clog2(MAX_POLL)+1 bits and never wraps.

## Timing

- Reset values: mosi=1, busy=0, done=0, rx_byte=0x00, timeout=0, state=IDLE. rx_sr, tx_sr and counters are cleared.
- rst asserted mid-transfer returns all state and outputs to reset values on that clk edge. No done is generated. The next start after rst deasserts operates normally.
- Start acceptance: start at cycle S gives busy=1 and mosi=tx_byte[7] at S+1.
- Completion latency:
  - 8th sclk_rise sampled at cycle N gives CHECK at N+1 and DONE at N+2.
  - done=1, with rx_byte and timeout valid, during N+2.
  - busy=0 at N+3.
  - Earliest accepted new start is at N+3.
- Poll mode:
  - Consecutive bytes are separated only by the CHECK cycle; mosi stays 1 throughout.
  - Total rises before done equals 8×(bytes clocked), at most 8×MAX_POLL.
- MOSI bit k (MSB=7) is stable from the sclk_fall following rise 7-k until the sclk_fall after rise 8-k. Bit 7 is stable from acceptance.

## Test plan

- Normal transfer: start, tx_byte=0xA5, poll=0, then 8 rise/fall pairs 4 clk apart with miso presenting 0x3C MSB first → mosi at each rise is 1,0,1,0,0,1,0,1; done one cycle, 2 clk after the 8th rise; rx_byte=0x3C; timeout=0; busy falls the next cycle.
- Poll success: start with poll=1, miso bytes 0xFF, 0xFF, 0x00 → exactly 24 rises consumed, mosi=1 throughout, done with rx_byte=0x00, timeout=0.
- Poll timeout: MAX_POLL=8, miso held 1 → done after exactly 64 rises, rx_byte=0xFF, timeout=1; further strobes leave rx_byte unchanged and busy=0.
- Protocol edges:
  - sclk_fall before the first rise → mosi holds the MSB.
  - start=1 with tx_byte=0x00 mid-transfer → no effect on the transfer in progress; first byte completes with the original data.
  - Simultaneous rise+fall → only the sample occurs.
- Reset mid-byte: rst after 3 rises of 0xA5 → next cycle busy=0, mosi=1, rx_byte=0x00, no done pulse. A fresh start with tx_byte=0x5A and miso 0xC3 completes with rx_byte=0xC3.
